// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data memory controller: FSM states, latched store request, lane byte helper.
package data_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_LAST = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } st_req_t;

  function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [1:0] lane);
    return 8'(data >> {lane, 3'b000});
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_sel.sv
// Next-set-lane finder: lowest set mask lane at or above 0 (from_start) or strictly above cur.
module dmem_lane_sel (
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  input  logic       from_start,
  output logic [1:0] next,
  output logic       last
);
  logic found;

  always_comb begin
    next  = cur;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && mask[i] && (from_start || (i > int'(cur)))) begin
        next  = 2'(i);
        found = 1'b1;
      end
    end
    last = !found;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Serialises 32-bit loads/stores from ME into single-byte RAM bus accesses.
// Optional one-entry last-word read cache: define DMEM_LAST_WORD_CACHE_EN.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_enable_i,
  input  logic              w_enable_i,
  input  logic [3:0]        w_mask_i,
  input  logic [31:0]       w_data_i,
  input  logic [31:0]       addr_i,
  output logic [31:0]       r_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o,
  input  logic              mem_ready_i,
  input  logic [7:0]        mem_din_i
);
  localparam int WA_W = ADDR_W - 2;

  state_t          state;
  logic [WA_W-1:0] word;
  logic [1:0]      cnt;
  st_req_t         wreq;
  logic            rd_pend;
  logic [23:0]     rd_buf;

  logic [WA_W-1:0] req_word;
  logic [1:0]      first_lane, next_lane;
  logic            mask_empty, wr_last;
  logic            unused_addr;

  assign req_word    = addr_i[ADDR_W-1:2];
  assign unused_addr = ^{addr_i[31:ADDR_W], addr_i[1:0]};

  dmem_lane_sel u_first (
    .mask       (w_mask_i),
    .cur        (2'd0),
    .from_start (1'b1),
    .next       (first_lane),
    .last       (mask_empty)
  );

  dmem_lane_sel u_next (
    .mask       (wreq.mask),
    .cur        (cnt),
    .from_start (1'b0),
    .next       (next_lane),
    .last       (wr_last)
  );

`ifdef DMEM_LAST_WORD_CACHE_EN
  logic            c_valid;
  logic [WA_W-1:0] c_tag;
  logic [31:0]     c_data;
  logic            c_hit;
  assign c_hit = c_valid && (c_tag == req_word);
`endif

  // Bus side is a pure decode of registered state so it never glitches on request inputs.
  assign busy_o     = (state == S_RD) || (state == S_RD_LAST) || (state == S_WR);
  assign done_o     = (state == S_DONE);
  assign mem_rd_o   = (state == S_RD);
  assign mem_wr_o   = (state == S_WR);
  assign mem_addr_o = {word, cnt};
  assign mem_dout_o = (state == S_WR) ? lane_byte(wreq.data, cnt) : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      word     <= '0;
      cnt      <= 2'd0;
      wreq     <= '0;
      rd_pend  <= 1'b0;
      rd_buf   <= '0;
      r_data_o <= '0;
`ifdef DMEM_LAST_WORD_CACHE_EN
      c_valid  <= 1'b0;
      c_tag    <= '0;
      c_data   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          rd_pend <= 1'b0;
          if (w_enable_i) begin
            word      <= req_word;
            wreq.mask <= w_mask_i;
            wreq.data <= w_data_i;
            cnt       <= first_lane;
            state     <= mask_empty ? S_DONE : S_WR;
`ifdef DMEM_LAST_WORD_CACHE_EN
            if (c_hit)
              for (int i = 0; i < 4; i++)
                if (w_mask_i[i]) c_data[8*i +: 8] <= lane_byte(w_data_i, 2'(i));
`endif
          end else if (r_enable_i) begin
            word <= req_word;
            cnt  <= 2'd0;
`ifdef DMEM_LAST_WORD_CACHE_EN
            if (c_hit) begin
              r_data_o <= c_data;
              state    <= S_DONE;
            end else begin
              state <= S_RD;
            end
`else
            state <= S_RD;
`endif
          end
        end

        S_RD: begin
          // Read data trails its accepted strobe by one cycle; a pending byte belongs to lane cnt-1.
          rd_pend <= mem_ready_i;
          if (rd_pend) begin
            case (cnt - 2'd1)
              2'd0:    rd_buf[7:0]   <= mem_din_i;
              2'd1:    rd_buf[15:8]  <= mem_din_i;
              default: rd_buf[23:16] <= mem_din_i;
            endcase
          end
          if (mem_ready_i) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= S_RD_LAST;
          end
        end

        S_RD_LAST: begin
          rd_pend  <= 1'b0;
          r_data_o <= {mem_din_i, rd_buf};
          state    <= S_DONE;
`ifdef DMEM_LAST_WORD_CACHE_EN
          c_valid <= 1'b1;
          c_tag   <= word;
          c_data  <= {mem_din_i, rd_buf};
`endif
        end

        S_WR: begin
          if (mem_ready_i) begin
            if (wr_last) state <= S_DONE;
            else         cnt   <= next_lane;
          end
        end

        S_DONE: begin
          cnt   <= 2'd0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: vector table, corner sequences, random ops vs a byte-array model.
module tb_data_mem_ctrl;
  localparam int ADDR_W = 17;
  localparam int MEM_SZ = 1 << ADDR_W;
  localparam logic [31:0] BASE_MASK = 32'(MEM_SZ - 4);

  logic              clk = 1'b0;
  logic              rst;
  logic              r_enable_i, w_enable_i;
  logic [3:0]        w_mask_i;
  logic [31:0]       w_data_i, addr_i, r_data_o;
  logic              busy_o, done_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o, mem_rd_o;
  logic              mem_ready_i = 1'b1;
  logic [7:0]        mem_din_i = 8'h00;

  int errors = 0;
  int checks = 0;

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .r_enable_i(r_enable_i), .w_enable_i(w_enable_i),
    .w_mask_i(w_mask_i), .w_data_i(w_data_i), .addr_i(addr_i), .r_data_o(r_data_o),
    .busy_o(busy_o), .done_o(done_o), .mem_addr_o(mem_addr_o), .mem_dout_o(mem_dout_o),
    .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o), .mem_ready_i(mem_ready_i), .mem_din_i(mem_din_i)
  );

  always #5 clk = ~clk;

  // Bus-side RAM (owned by one process) and the reference model memory.
  logic [7:0] ram [0:MEM_SZ-1];
  logic [7:0] mdl [0:MEM_SZ-1];
  logic       load_ram = 1'b0;
  int         rd_strobes = 0, wr_acc = 0, stall_seen = 0, stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [ADDR_W+9:0] prev_bus = '0;
  int         rdy_mode = 0;

  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < MEM_SZ; i++) ram[i] <= mdl[i];
    end else if (!rst) begin
      if (mem_rd_o && mem_ready_i) mem_din_i <= ram[mem_addr_o];
      if (mem_wr_o && mem_ready_i) begin
        ram[mem_addr_o] <= mem_dout_o;
        wr_acc <= wr_acc + 1;
      end
      if (mem_rd_o) rd_strobes <= rd_strobes + 1;
      if (prev_stall) begin
        stall_seen <= stall_seen + 1;
        if ({mem_rd_o, mem_wr_o, mem_addr_o, mem_dout_o} != prev_bus) stall_viol <= stall_viol + 1;
      end
      prev_stall <= (mem_rd_o || mem_wr_o) && !mem_ready_i;
      prev_bus   <= {mem_rd_o, mem_wr_o, mem_addr_o, mem_dout_o};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  always @(negedge clk) begin
    case (rdy_mode)
      0:       mem_ready_i = 1'b1;
      1:       mem_ready_i = ~mem_ready_i;
      default: mem_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] addr);
    int b;
    b = int'(addr & BASE_MASK);
    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
  endfunction

  task automatic mdl_store(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    int b;
    b = int'(addr & BASE_MASK);
    for (int i = 0; i < 4; i++)
      if (mask[i]) mdl[b+i] = 8'(data >> (8*i));
  endtask

  // Issues one request held until done_o; lat = edges from acceptance edge T to done sample.
  task automatic run_req(input logic w, input logic r, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data,
                         output int lat, output logic [31:0] rdata, output int nrd, output int nwr);
    int rd0, wr0;
    @(negedge clk);
    rd0 = rd_strobes; wr0 = wr_acc;
    w_enable_i = w; r_enable_i = r; addr_i = addr; w_mask_i = mask; w_data_i = data;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done_o) begin lat = k; break; end
    end
    rdata = r_data_o;
    nrd = rd_strobes - rd0;
    nwr = wr_acc - wr0;
    w_enable_i = 1'b0; r_enable_i = 1'b0;
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    if (w) mdl_store(addr, mask, data);
  endtask

  typedef struct {
    logic        w, r;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data, exp_rdata;
    int          exp_lat, exp_rd, exp_wr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat, nrd, nwr, n;
    logic [31:0] rd, a, d, exp;
    logic [3:0] m;
    logic w;

    vecs[0] = '{1'b0, 1'b1, 32'h40,    4'b0000, 32'h0,        32'h44332211, 6, 4, 0};
    vecs[1] = '{1'b1, 1'b0, 32'h81,    4'b0010, 32'hAABBCCDD, 32'h44332211, 2, 0, 1};
    vecs[2] = '{1'b0, 1'b1, 32'h80,    4'b0000, 32'h0,        32'h0403CC01, 6, 4, 0};
    vecs[3] = '{1'b1, 1'b0, 32'h102,   4'b0000, 32'hFFFFFFFF, 32'h0403CC01, 1, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h100,   4'b1111, 32'hDEADBEEF, 32'h0403CC01, 5, 0, 4};
    vecs[5] = '{1'b0, 1'b1, 32'h103,   4'b0000, 32'h0,        32'hDEADBEEF, 6, 4, 0};
    vecs[6] = '{1'b1, 1'b0, 32'h20081, 4'b1001, 32'h12345678, 32'hDEADBEEF, 3, 0, 2};
    vecs[7] = '{1'b0, 1'b1, 32'h80,    4'b0000, 32'h0,        32'h1203CC78, 6, 4, 0};
    vecs[8] = '{1'b1, 1'b0, 32'h41,    4'b1100, 32'hA1B2C3D4, 32'h1203CC78, 3, 0, 2};
    vecs[9] = '{1'b0, 1'b1, 32'h40,    4'b0000, 32'h0,        32'hA1B22211, 6, 4, 0};

    rst = 1'b1;
    r_enable_i = 1'b0; w_enable_i = 1'b0; w_mask_i = 4'h0; w_data_i = '0; addr_i = '0;
    for (int i = 0; i < MEM_SZ; i++) mdl[i] = 8'(i * 7 + 3);
    {mdl[32'h43], mdl[32'h42], mdl[32'h41], mdl[32'h40]} = 32'h44332211;
    {mdl[32'h83], mdl[32'h82], mdl[32'h81], mdl[32'h80]} = 32'h04030201;
    load_ram = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_ram = 1'b0;
    check("reset_outputs", {busy_o, done_o, mem_wr_o, mem_rd_o, 28'h0},  32'h0);
    check("reset_bus", {mem_dout_o, 7'h0, mem_addr_o}, 32'h0);
    check("reset_rdata", r_data_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Vector table, ready held high.
    for (int v = 0; v < 10; v++) begin
      run_req(vecs[v].w, vecs[v].r, vecs[v].addr, vecs[v].mask, vecs[v].data, lat, rd, nrd, nwr);
      check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("vec%0d_rd", v), 32'(nrd), 32'(vecs[v].exp_rd));
      check($sformatf("vec%0d_wr", v), 32'(nwr), 32'(vecs[v].exp_wr));
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
    end

    // Load with ready toggling every cycle.
    rdy_mode = 1;
    run_req(1'b0, 1'b1, 32'h80, 4'h0, 32'h0, lat, rd, nrd, nwr);
    rdy_mode = 0;
    check("stall_rdata", rd, 32'h1203CC78);
    check("stall_later", 32'(lat > 6), 32'd1);
    check("stall_seen", 32'(stall_seen > 0), 32'd1);
    check("stall_stable", 32'(stall_viol), 32'd0);

    // Both enables high: store wins, no read strobe.
    run_req(1'b1, 1'b1, 32'h200, 4'b0001, 32'h0000005A, lat, rd, nrd, nwr);
    check("both_rd", 32'(nrd), 32'd0);
    check("both_wr", 32'(nwr), 32'd1);
    check("both_lat", 32'(lat), 32'd2);
    run_req(1'b0, 1'b1, 32'h200, 4'h0, 32'h0, lat, rd, nrd, nwr);
    check("both_readback", rd, mdl_load(32'h200));

    // Reset while the third byte of a load is on the bus.
    @(negedge clk);
    r_enable_i = 1'b1; addr_i = 32'h100;
    n = 0;
    while (!(mem_rd_o && mem_addr_o[1:0] == 2'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_byte2", 32'(n < 50), 32'd1);
    rst = 1'b1; r_enable_i = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {busy_o, done_o, mem_wr_o, mem_rd_o, 28'h0}, 32'h0);
    check("rst_mid_bus", {mem_dout_o, 7'h0, mem_addr_o}, 32'h0);
    check("rst_mid_rdata", r_data_o, 32'h0);
    rst = 1'b0;
    run_req(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, lat, rd, nrd, nwr);
    check("rst_after_rdata", rd, 32'hDEADBEEF);
    check("rst_after_lat", 32'(lat), 32'd6);

`ifdef DMEM_LAST_WORD_CACHE_EN
    run_req(1'b0, 1'b1, 32'h40, 4'h0, 32'h0, lat, rd, nrd, nwr);
    check("cache_miss_lat", 32'(lat), 32'd6);
    run_req(1'b1, 1'b0, 32'h42, 4'b0100, 32'h00990000, lat, rd, nrd, nwr);
    run_req(1'b0, 1'b1, 32'h40, 4'h0, 32'h0, lat, rd, nrd, nwr);
    check("cache_hit_lat", 32'(lat), 32'd1);
    check("cache_hit_rd", 32'(nrd), 32'd0);
    check("cache_hit_rdata", rd, 32'hA1992211);
`endif

    // Random loads/stores with random bus backpressure against the model.
    rdy_mode = 2;
    for (int t = 0; t < 60; t++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFE0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      m = 4'($urandom);
      d = $urandom;
      exp = mdl_load(a);
      run_req(w, ~w, a, m, d, lat, rd, nrd, nwr);
      if (w) check($sformatf("rnd%0d_wr", t), 32'(nwr), 32'($countones(m)));
      else   check($sformatf("rnd%0d_rdata", t), rd, exp);
    end
    rdy_mode = 0;
    check("rnd_stall_stable", 32'(stall_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
